cache_arbiter: RTL

Two-port arbiter that shares the single 256-bit line-level memory port (L2 / prefetcher side) between the instruction-cache miss path and the data-cache miss/writeback path. It sits between the L1 caches and the next memory level. It serialises requests, latches the winner's command, address and write data, and routes the response back to the granted requester only. By default, data-side requests have fixed priority; round-robin is available as a compile-time option.

---
 rtl/cache_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one 256-bit line-level memory port between the
// I-cache miss path and the D-cache miss/writeback path.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   i_read/i_address    I-cache line read request (held until i_resp)
//   i_rdata/i_resp      line data / one-cycle completion to I-cache
//   d_read/d_write      D-cache line read / writeback request (held until d_resp)
//   d_address/d_wdata   D-cache line address / writeback data
//   d_rdata/d_resp      line data / one-cycle completion to D-cache
//   mem_read/mem_write  registered command to next level
//   mem_address/wdata   winner's address / data, latched on grant
//   mem_rdata/mem_resp  line data / completion from next level
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both
// sides request in the same IDLE cycle; otherwise D always wins.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t state;
  logic   last_grant;  // 0 = I, 1 = D
  logic   d_req;
  logic   grant_d;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention, hand the port to whoever did not get it last time.
  assign grant_d = d_req & (~i_read | ~last_grant);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      last_grant  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            // read+write together is resolved as a writeback
            state       <= SERVE_D;
            mem_write   <= d_write;
            mem_read    <= ~d_write;
            mem_address <= d_address;
            mem_wdata   <= d_wdata;
            last_grant  <= 1'b1;
          end else if (i_read) begin
            state       <= SERVE_I;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= i_address;
            mem_wdata   <= '0;
            last_grant  <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is passed through combinationally, gated to the granted side;
  // mem_resp outside a SERVE state produces nothing.
  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE)
      assert (!(d_read && d_write))
        else $error("cache_arbiter: d_read and d_write both high, treated as write");
  end
`endif

endmodule
